// File: rtl/rr_arbiter_wh_if.sv
// Handshake bundle between the NoC input ports and one output-port arbiter.
// The slave side is the arbiter. The master side drives requests and flow control.
interface rr_arbiter_wh_if #(
    parameter int N     = 5,
    parameter int IDX_W = 3
);
    logic [N-1:0]     request;
    logic             ready;
    logic             tail;
    logic [N-1:0]     grant_oh;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             locked;

    modport master (
        output request, ready, tail,
        input  grant_oh, grant_idx, grant_valid, locked
    );

    modport slave (
        input  request, ready, tail,
        output grant_oh, grant_idx, grant_valid, locked
    );
endinterface

// File: rtl/rr_arbiter_wh.sv
// Round-robin arbiter with wormhole grant locking for one NoC router output port.
// It holds a grant until the tail flit transfers, or until the winner drops its request.
module rr_arbiter_wh #(
    parameter int N     = 5,
    parameter int IDX_W = 3,
    parameter int LOCK  = 1
) (
    input  logic           clk,
    input  logic           reset,
    rr_arbiter_wh_if.slave arb
);
    localparam int PW = 2 ** IDX_W;
    localparam int SW = IDX_W + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] last_reg, last_next;
    logic [IDX_W-1:0] grant_idx_reg, grant_idx_next;
    logic             grant_valid_reg, grant_valid_next;
    logic [N-1:0]     grant_oh_reg, grant_oh_next;

    logic [PW-1:0]    req_pad;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] cand_idx [N];
    logic [N-1:0]     rot_req;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             lock_off;
    logic             held;
    logic             xfer;
    logic             release_grant;

    assign req_pad  = PW'(arb.request);
    assign lock_off = (LOCK == 0);

    // Scan starts one past base. The base's own bit is visited last.
    // A lone requester that equals the previous winner is therefore still picked.
    assign base = (state_reg == IDLE) ? last_reg : grant_idx_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [SW-1:0] sum;
            assign sum          = {1'b0, base} + SW'(gi + 1);
            assign cand_idx[gi] = (sum >= SW'(N)) ? IDX_W'(sum - SW'(N)) : sum[IDX_W-1:0];
            assign rot_req[gi]  = req_pad[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!pick_found && rot_req[k]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    assign held          = req_pad[grant_idx_reg];
    assign xfer          = grant_valid_reg & arb.ready & held;
    assign release_grant = (xfer & (arb.tail | lock_off)) | (grant_valid_reg & ~held);

    always_comb begin
        state_next       = state_reg;
        last_next        = last_reg;
        grant_idx_next   = grant_idx_reg;
        grant_valid_next = grant_valid_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next       = LOCKED;
                    grant_idx_next   = pick_idx;
                    grant_valid_next = 1'b1;
                end
            end
            LOCKED: begin
                if (release_grant) begin
                    last_next = grant_idx_reg;
                    if (pick_found) begin
                        grant_idx_next = pick_idx;
                    end else begin
                        state_next       = IDLE;
                        grant_idx_next   = '0;
                        grant_valid_next = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        grant_oh_next = grant_valid_next ? (N'(1) << grant_idx_next) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            last_reg        <= IDX_W'(N - 1);
            grant_idx_reg   <= '0;
            grant_valid_reg <= 1'b0;
            grant_oh_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            last_reg        <= last_next;
            grant_idx_reg   <= grant_idx_next;
            grant_valid_reg <= grant_valid_next;
            grant_oh_reg    <= grant_oh_next;
        end
    end

    assign arb.grant_oh    = grant_oh_reg;
    assign arb.grant_idx   = grant_idx_reg;
    assign arb.grant_valid = grant_valid_reg;
    assign arb.locked      = ~lock_off & (state_reg == LOCKED);
endmodule

// File: tb/tb_rr_arbiter_wh.sv
// Scoreboard bench for rr_arbiter_wh: a wormhole build (LOCK=1) and a per-flit build (LOCK=0)
// share the same stimulus. Each is checked against a queue-fed reference model.
module tb_rr_arbiter_wh;
    localparam int N     = 5;
    localparam int IDX_W = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rr_arbiter_wh_if #(.N(N), .IDX_W(IDX_W)) if_l ();
    rr_arbiter_wh_if #(.N(N), .IDX_W(IDX_W)) if_r ();

    rr_arbiter_wh #(.N(N), .IDX_W(IDX_W), .LOCK(1)) u_dut_lock (
        .clk   (clk),
        .reset (reset),
        .arb   (if_l)
    );

    rr_arbiter_wh #(.N(N), .IDX_W(IDX_W), .LOCK(0)) u_dut_rr (
        .clk   (clk),
        .reset (reset),
        .arb   (if_r)
    );

    typedef struct {
        int valid;
        int idx;
        int oh;
        int lk;
    } exp_t;

    exp_t q_l[$];
    exp_t q_r[$];
    int   owner [2];
    int   last  [2];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // First requester found walking upward from base+1 with wrap-around.
    function automatic int rr_pick(int req, int base);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (base + k) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic exp_t model_step(int m, int lockp, bit rst, int req, bit rdy, bit tl);
        exp_t e;
        bit   hold_req;
        bit   xf;
        int   masked;
        if (rst) begin
            owner[m] = -1;
            last[m]  = N - 1;
        end else if (owner[m] < 0) begin
            owner[m] = rr_pick(req, last[m]);
        end else begin
            hold_req = req[owner[m]];
            xf       = rdy && hold_req;
            if ((xf && (tl || lockp == 0)) || !hold_req) begin
                last[m] = owner[m];
                masked  = req & ~(1 << owner[m]);
                owner[m] = (masked != 0) ? rr_pick(masked, owner[m]) : rr_pick(req, owner[m]);
            end
        end
        e.valid = (owner[m] >= 0) ? 1 : 0;
        e.idx   = (owner[m] >= 0) ? owner[m] : 0;
        e.oh    = (owner[m] >= 0) ? (1 << owner[m]) : 0;
        e.lk    = (lockp != 0 && owner[m] >= 0) ? 1 : 0;
        return e;
    endfunction

    task automatic drive(bit rst, int req, bit rdy, bit tl);
        reset        = rst;
        if_l.request = N'(req);
        if_r.request = N'(req);
        if_l.ready   = rdy;
        if_r.ready   = rdy;
        if_l.tail    = tl;
        if_r.tail    = tl;
        q_l.push_back(model_step(0, 1, rst, req, rdy, tl));
        q_r.push_back(model_step(1, 0, rst, req, rdy, tl));
        @(negedge clk);
    endtask

    task automatic check(string nm, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
        end
    endtask

    // Monitor: every cycle the DUTs present a new registered grant, so pop one expectation per DUT.
    initial begin
        exp_t el;
        exp_t er;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q_l.size() > 0 && q_r.size() > 0) begin
                el = q_l.pop_front();
                er = q_r.pop_front();
                check("lock_valid",  int'(if_l.grant_valid), el.valid);
                check("lock_idx",    int'(if_l.grant_idx),   el.idx);
                check("lock_oh",     int'(if_l.grant_oh),    el.oh);
                check("lock_locked", int'(if_l.locked),      el.lk);
                check("rr_valid",    int'(if_r.grant_valid), er.valid);
                check("rr_idx",      int'(if_r.grant_idx),   er.idx);
                check("rr_oh",       int'(if_r.grant_oh),    er.oh);
                check("rr_locked",   int'(if_r.locked),      er.lk);
                $display("cyc=%0d req=%b rdy=%b tail=%b | lock v=%0d idx=%0d lk=%0d | rr v=%0d idx=%0d",
                         cyc, if_l.request, if_l.ready, if_l.tail, if_l.grant_valid,
                         if_l.grant_idx, if_l.locked, if_r.grant_valid, if_r.grant_idx);
            end
        end
    end

    initial begin
        int  req;
        bit  rdy;
        bit  tl;
        bit  rst;
        // reset, then a single requester gets idx 0 one cycle later
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 5'b00001, 1, 0);
        drive(0, 5'b00001, 1, 0);
        // packet on idx 0 held for body flits, then back-to-back hand-over to idx 2
        for (int i = 0; i < 3; i++) drive(0, 5'b00101, 1, 0);
        drive(0, 5'b00101, 1, 1);
        drive(0, 5'b00101, 1, 0);
        drive(0, 5'b00101, 1, 0);
        // single-flit packets from everyone: fair rotation with wrap
        drive(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 5'b11111, 1, 1);
        // lock hold with ready low
        drive(1, 0, 0, 0);
        drive(0, 5'b00010, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 5'b11111, 0, 0);
        // abort to idx 4, then a tail with nobody left goes idle
        drive(1, 0, 0, 0);
        drive(0, 5'b00100, 0, 0);
        drive(0, 5'b00100, 0, 0);
        drive(0, 5'b10000, 0, 0);
        drive(0, 5'b10000, 1, 1);
        drive(0, 5'b00000, 0, 0);
        drive(0, 5'b00000, 0, 0);
        // reset while locked on idx 3 wins over the pending request
        drive(1, 0, 0, 0);
        drive(0, 5'b01000, 0, 0);
        drive(0, 5'b01000, 0, 0);
        drive(1, 5'b11111, 1, 1);
        drive(0, 5'b11111, 0, 0);
        drive(0, 5'b11111, 0, 0);
        // two requesters, no tails: per-flit build alternates, wormhole build holds
        drive(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 5'b00110, 1, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            req = int'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) req = req & int'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) req = 0;
            rdy = ($urandom_range(0, 3) != 0);
            tl  = ($urandom_range(0, 9) < 3);
            drive(rst, req, rdy, tl);
        end
        @(posedge clk);
        #2;
        check("scoreboard_drained", q_l.size() + q_r.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
